// File: rtl/cond_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval_pipe
// Purpose  : Pipelined multi-mode condition evaluator (MOVZ/MOVN, branches,
//            set-less-than) with stall/flush and a saturating taken counter.
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             cond,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] c_mode_eqz = 4'd0;
  localparam logic [3:0] c_mode_nez = 4'd1;
  localparam logic [3:0] c_mode_eq  = 4'd2;
  localparam logic [3:0] c_mode_ne  = 4'd3;
  localparam logic [3:0] c_mode_lez = 4'd4;
  localparam logic [3:0] c_mode_gtz = 4'd5;
  localparam logic [3:0] c_mode_ltz = 4'd6;
  localparam logic [3:0] c_mode_gez = 4'd7;
  localparam logic [3:0] c_mode_lt  = 4'd8;
  localparam logic [3:0] c_mode_ltu = 4'd9;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic w_a_zero;
  logic w_a_neg;
  logic w_cond;
  logic w_illegal;
  logic w_consume;

  // Index 0 is stage 1; index LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_cond;
  logic [LATENCY-1:0] r_ill;
  logic [CNT_W-1:0]   r_cnt;

  assign w_a_zero = (a == '0);
  assign w_a_neg  = a[WIDTH-1];

  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (mode)
      c_mode_eqz: w_cond = w_a_zero;
      c_mode_nez: w_cond = ~w_a_zero;
      c_mode_eq:  w_cond = (a == b);
      c_mode_ne:  w_cond = (a != b);
      c_mode_lez: w_cond = w_a_neg | w_a_zero;
      c_mode_gtz: w_cond = ~w_a_neg & ~w_a_zero;
      c_mode_ltz: w_cond = w_a_neg;
      c_mode_gez: w_cond = ~w_a_neg;
      c_mode_lt:  w_cond = ($signed(a) < $signed(b));
      c_mode_ltu: w_cond = (a < b);
      default:    w_illegal = 1'b1;
    endcase
  end

  // Stage 1 captures only unstalled, unflushed input; empty stages carry zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld[0]  <= 1'b0;
      r_cond[0] <= 1'b0;
      r_ill[0]  <= 1'b0;
    end else if (flush) begin
      r_vld[0]  <= 1'b0;
      r_cond[0] <= 1'b0;
      r_ill[0]  <= 1'b0;
    end else if (!stall) begin
      r_vld[0]  <= in_valid;
      r_cond[0] <= in_valid & w_cond;
      r_ill[0]  <= in_valid & w_illegal;
    end
  end

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_vld[gi]  <= 1'b0;
        r_cond[gi] <= 1'b0;
        r_ill[gi]  <= 1'b0;
      end else if (flush) begin
        r_vld[gi]  <= 1'b0;
        r_cond[gi] <= 1'b0;
        r_ill[gi]  <= 1'b0;
      end else if (!stall) begin
        r_vld[gi]  <= r_vld[gi-1];
        r_cond[gi] <= r_cond[gi-1];
        r_ill[gi]  <= r_ill[gi-1];
      end
    end
  end

  // A result is counted once, on the edge where it is actually consumed.
  assign w_consume = r_vld[LATENCY-1] & r_cond[LATENCY-1] & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_consume && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_vld[LATENCY-1];
  assign cond      = r_cond[LATENCY-1];
  assign illegal   = r_ill[LATENCY-1];
  assign taken_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_eval_pipe
// Purpose  : Directed self-checking bench for cond_eval_pipe (LATENCY=3, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_eval_pipe;

  localparam int WIDTH = 32;
  localparam int LAT   = 3;
  localparam int CW    = 4;

  logic             clk      = 1'b0;
  logic             reset    = 1'b0;
  logic             in_valid = 1'b0;
  logic             stall    = 1'b0;
  logic             flush    = 1'b0;
  logic             cnt_clr  = 1'b0;
  logic [3:0]       mode     = '0;
  logic [WIDTH-1:0] a        = '0;
  logic [WIDTH-1:0] b        = '0;
  logic             out_valid;
  logic             cond;
  logic             illegal;
  logic [CW-1:0]    taken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cond_eval_pipe #(
    .WIDTH  (WIDTH),
    .LATENCY(LAT),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .stall    (stall),
    .flush    (flush),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .cnt_clr  (cnt_clr),
    .out_valid(out_valid),
    .cond     (cond),
    .illegal  (illegal),
    .taken_cnt(taken_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] m, input logic [31:0] aa, input logic [31:0] bb);
    in_valid = v;
    mode     = m;
    a        = aa;
    b        = bb;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    stall   = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic clear_cnt();
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'($urandom), $urandom, $urandom);
      stall   = 1'($urandom);
      cnt_clr = 1'($urandom);
      tick();
      n_cmp++;
      if ({out_valid, cond, illegal, taken_cnt} !== 7'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got v=%b c=%b i=%b cnt=%0d, want all 0", i, out_valid, cond, illegal, taken_cnt);
      end
    end
    idle();
    #2 reset = 1'b1;
    drive(1'b1, 4'd0, 32'd0, 32'd0);
    tick();
    idle();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_early: got out_valid=%b want 0", out_valid);
    end
    tick();
    n_cmp++;
    if ({out_valid, cond, illegal} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_first_op: got v/c/i=%b want 110", {out_valid, cond, illegal});
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || taken_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL reset_first_after: got v=%b cnt=%0d want v=0 cnt=1", out_valid, taken_cnt);
    end
    // Fill the pipe, then drop reset between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd0, 32'd0, 32'd0);
      tick();
    end
    idle();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, cond, taken_cnt} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b c=%b cnt=%0d want all 0", out_valid, cond, taken_cnt);
    end
    #1 reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_mode_sweep();
    bit ec [16] = '{0,1,0,1,1,0,1,0,1,0,0,0,0,0,0,0};
    bit ei [16] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1};
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, 4'(k), 32'h8000_0000, 32'h0000_0001);
      else        idle();
      tick();
      if (k >= 2) begin
        n_cmp++;
        if ({out_valid, cond, illegal} !== {1'b1, ec[k-2], ei[k-2]}) begin
          n_err++;
          $display("FAIL mode_sweep[mode %0d]: got v/c/i=%b want %b", k-2,
                   {out_valid, cond, illegal}, {1'b1, ec[k-2], ei[k-2]});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  om [8] = '{4'd2, 4'd2, 4'd9, 4'd8, 4'd3, 4'd7, 4'd4, 4'd5};
    logic [31:0] oa [8] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ob [8] = '{32'd5, 32'd6, 32'd0, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0};
    bit          oc [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    logic        ev;
    logic        ecnd;
    clear_cnt();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1'b1, om[k], oa[k], ob[k]);
      else       idle();
      tick();
      ev   = (k >= 2 && k <= 9);
      ecnd = ev ? oc[k-2] : 1'b0;
      n_cmp++;
      if ({out_valid, cond} !== {ev, ecnd}) begin
        n_err++;
        $display("FAIL back_to_back[cycle %0d]: got v/c=%b want %b", k, {out_valid, cond}, {ev, ecnd});
      end
    end
    n_cmp++;
    if (taken_cnt !== 4'd4) begin
      n_err++;
      $display("FAIL b2b_count: got taken_cnt=%0d want 4", taken_cnt);
    end
  endtask

  task automatic test_stall();
    bit          tv [10] = '{1,1,1,1,1,1,1,0,0,0};
    bit          ts [10] = '{0,0,0,1,1,0,0,0,0,0};
    logic [3:0]  tm [10] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd12, 4'd6, 4'd0, 4'd0, 4'd0};
    logic [31:0] ta [10] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
    logic [2:0]  eo [10] = '{3'b000, 3'b000, 3'b110, 3'b110, 3'b110, 3'b100, 3'b110, 3'b101, 3'b110, 3'b000};
    for (int t = 0; t < 10; t++) begin
      drive(tv[t], tm[t], ta[t], 32'd0);
      stall   = ts[t];
      cnt_clr = (t == 0);
      tick();
      n_cmp++;
      if ({out_valid, cond, illegal} !== eo[t]) begin
        n_err++;
        $display("FAIL stall[cycle %0d]: got v/c/i=%b want %b", t, {out_valid, cond, illegal}, eo[t]);
      end
    end
    idle();
    n_cmp++;
    if (taken_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL stall_count: got taken_cnt=%0d want 3", taken_cnt);
    end
  endtask

  task automatic test_flush();
    bit         tv [11] = '{1,1,1,1,0,0,0,1,0,0,0};
    logic [2:0] eo [11] = '{3'b000, 3'b000, 3'b110, 3'b000, 3'b000, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b110, 3'b000};
    logic [3:0] ecnt;
    for (int t = 0; t < 11; t++) begin
      drive(tv[t], 4'd0, 32'd0, 32'd0);
      stall   = (t == 3);
      flush   = (t == 3);
      cnt_clr = (t == 0);
      tick();
      ecnt = (t == 10) ? 4'd1 : 4'd0;
      n_cmp++;
      if ({out_valid, cond, illegal} !== eo[t] || taken_cnt !== ecnt) begin
        n_err++;
        $display("FAIL flush[cycle %0d]: got v/c/i=%b cnt=%0d want %b cnt=%0d",
                 t, {out_valid, cond, illegal}, taken_cnt, eo[t], ecnt);
      end
    end
    idle();
  endtask

  task automatic test_counter();
    int exp_cnt;
    clear_cnt();
    for (int k = 0; k < 23; k++) begin
      if (k < 20) drive(1'b1, 4'd0, 32'd0, 32'd0);
      else        idle();
      tick();
      exp_cnt = (k < 2) ? 0 : ((k - 2 > 15) ? 15 : k - 2);
      n_cmp++;
      if (taken_cnt !== 4'(exp_cnt)) begin
        n_err++;
        $display("FAIL counter_sat[cycle %0d]: got taken_cnt=%0d want %0d", k, taken_cnt, exp_cnt);
      end
    end
    drive(1'b1, 4'd0, 32'd0, 32'd0);
    tick();
    idle();
    tick();
    tick();
    n_cmp++;
    if ({out_valid, cond} !== 2'b11 || taken_cnt !== 4'd15) begin
      n_err++;
      $display("FAIL counter_pre_clr: got v/c=%b cnt=%0d want 11 cnt=15", {out_valid, cond}, taken_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++;
    if (taken_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL counter_clr_priority: got taken_cnt=%0d want 0", taken_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mode_sweep();
    test_back_to_back();
    test_stall();
    test_flush();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cond_eval_pipe.md
# cond_eval_pipe

Parametrised, pipelined condition evaluator for the datapath: generalises the single zero-test used by MOVZ into a multi-mode comparator covering conditional moves (MOVZ/MOVN), branch conditions (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ) and set-less-than. It sits beside the ALU in the EX stage, accepts one operation per cycle, returns the condition bit after a configurable register latency, honours pipeline stall/flush, and keeps a saturating count of true conditions for performance debug.

## Interface
- WIDTH, 32, operand width in bits (≥2)
- LATENCY, 1, register stages between input and output (1–4)
- CNT_W, 16, width of the true-condition counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation present on mode/a/b
- stall  in  1  freeze all stages; inputs ignored
- flush  in  1  kill all in-flight operations
- mode  in  4  condition select (see Operation)
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt); unused by zero-compare modes
- cnt_clr  in  1  synchronous clear of taken_cnt
- out_valid  out  1  cond/illegal valid this cycle
- cond  out  1  evaluated condition
- illegal  out  1  mode was reserved (10–15)
- taken_cnt  out  CNT_W  saturating count of emitted cond=1 results

## Operation
- Mode encoding (signed = two's complement of WIDTH bits): 0 EQZ a==0; 1 NEZ a!=0; 2 EQ a==b; 3 NE a!=b; 4 LEZ a≤0; 5 GTZ a>0; 6 LTZ a<0; 7 GEZ a≥0; 8 LT signed a<b; 9 LTU unsigned a<b; 10–15 reserved → cond=0, illegal=1.
- Evaluation is combinational at the input; result (cond, illegal, valid bit) enters stage 1 and shifts one stage per unstalled cycle; out_* driven from stage LATENCY registers.
- Accept: stage 1 loads valid=in_valid when stall=0 and flush=0.
- Stall=1 (flush=0): every stage holds, including out_valid/cond/illegal; in_valid dropped (upstream must hold).
- Flush=1: all stage valid bits cleared next edge, regardless of stall or in_valid; same-cycle input discarded; cond/illegal in flushed stages forced 0.
- Stage with valid=0 carries cond=0, illegal=0.
- taken_cnt: increments when out_valid=1, cond=1, stall=0, flush=0; saturates at 2^CNT_W−1; cnt_clr=1 forces 0 and overrides increment. Illegal results never count (cond=0).

## Timing
- Reset (reset=0, asynchronous): out_valid=0, cond=0, illegal=0, taken_cnt=0, all stage registers 0; reset mid-pipeline discards all in-flight ops immediately.
- Latency: op accepted at edge N appears on out_* after edge N+LATENCY−1 (valid during cycle N+LATENCY), given no stall. Each stall cycle adds one cycle.
- Throughput: one op per cycle, back-to-back, no bubbles inserted.
- An output is consumed in any cycle with out_valid=1 and stall=0; while stall=1 it is re-presented unchanged.
- Priority per edge: reset > flush > stall > normal shift; cnt_clr > increment.
- Boundaries: a = 2^(WIDTH−1) (most negative) → LTZ=1, LEZ=1, GTZ=0; LTU with a=0xFFFFFFFF,b=0 → 0; LT with same → 1.

## Test plan
- Reset: hold reset=0 with random inputs → out_valid=0, cond=0, taken_cnt=0; release, first op mode=0 a=0 → LATENCY cycles later out_valid=1, cond=1.
- Mode sweep (WIDTH=32): a=0x80000000, b=0x00000001, modes 0–9 → cond = 0,1,0,1,1,0,1,0,1,0; modes 10–15 → cond=0, illegal=1.
- Back-to-back with LATENCY=3: 8 consecutive ops → 8 consecutive out_valid cycles, order preserved, starting 3 cycles after first accept.
- Stall: insert stall=1 for 2 cycles mid-stream (in_valid=1 during stall) → outputs held constant, stalled-cycle inputs absent from output, total latency +2.
- Flush: flush=1 with 3 ops in flight and in_valid=1 → next cycles out_valid=0 until a new op is accepted; taken_cnt unchanged.
- Counter: CNT_W=4, 20 ops of mode=0 a=0 → taken_cnt saturates at 15; cnt_clr=1 coincident with a cond=1 output → taken_cnt=0.
